// File: rtl/sram_8blk_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sram_8blk_ctrl
//  Brief    : Master for the 8-block coefficient SRAM (8 x 256 x DW).
//             Load phase streams 2048 coefficients serially through the
//             shared CADDR/D write port; run phase issues 8 parallel block
//             reads per request and returns them with a fixed 2-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_8blk_ctrl #(
    parameter int DW   = 20,
    parameter int AW   = 8,
    parameter int NBLK = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // coefficient load port
    input  logic                 load_start,
    input  logic                 wr_valid,
    input  logic [DW-1:0]        wr_data,
    output logic                 wr_ready,
    output logic                 load_done,
    output logic                 loaded,
    // parallel read port
    input  logic                 rd_req,
    input  logic [NBLK*AW-1:0]   rd_addr,
    output logic                 rd_ready,
    output logic                 rd_valid,
    output logic [NBLK*DW-1:0]   rd_data,
    // SRAM side
    output logic                 CEN,
    output logic                 WEN,
    output logic [DW-1:0]        D,
    output logic [AW+$clog2(NBLK)-1:0] CADDR,
    output logic [NBLK*AW-1:0]   A,
    input  logic [NBLK*DW-1:0]   Q
);

    // Write counter spans every word of every block: {block, word}
    localparam int              c_CW        = AW + $clog2(NBLK);
    localparam logic [c_CW-1:0] c_WCNT_ONE  = {{(c_CW-1){1'b0}}, 1'b1};
    localparam logic [c_CW-1:0] c_WCNT_LAST = {c_CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CW-1:0]     r_wcnt;
    logic                r_wr_ready;
    logic                r_rd_ready;
    logic                r_load_done;
    logic                r_loaded;

    logic                r_cen;
    logic                r_wen;
    logic [DW-1:0]       r_d;
    logic [c_CW-1:0]     r_caddr;
    logic [NBLK*AW-1:0]  r_a;

    logic                r_rd_p1;    // address presented to the SRAM
    logic                r_rd_p2;    // SRAM has captured, Q is valid
    logic                r_rd_valid;
    logic [NBLK*DW-1:0]  r_rd_data;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_last_beat;

    // Handshakes use the registered readies, so acceptance depends only on current state
    assign w_wr_acc    = wr_valid & r_wr_ready;
    assign w_rd_acc    = rd_req & r_rd_ready;
    assign w_last_beat = w_wr_acc && (r_wcnt == c_WCNT_LAST);

    // Control FSM with registered status/handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_wr_ready  <= 1'b0;
            r_rd_ready  <= 1'b0;
            r_load_done <= 1'b0;
            r_loaded    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_load_done <= 1'b0;
                    if (load_start) begin
                        r_state    <= S_LOAD;
                        r_wcnt     <= '0;
                        r_loaded   <= 1'b0;
                        r_wr_ready <= 1'b1;
                        r_rd_ready <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_last_beat) begin
                        r_state     <= S_DONE;
                        r_wr_ready  <= 1'b0;
                        r_load_done <= 1'b1;
                    end else if (w_wr_acc) begin
                        r_wcnt <= r_wcnt + c_WCNT_ONE;
                    end
                end
                S_DONE: begin
                    // final write lands on this edge, contents now valid
                    r_state     <= S_IDLE;
                    r_load_done <= 1'b0;
                    r_loaded    <= 1'b1;
                    r_rd_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_wr_ready  <= 1'b0;
                    r_rd_ready  <= 1'b0;
                    r_load_done <= 1'b0;
                end
            endcase
        end
    end

    // SRAM drive: write beat, parallel read, or deselect; data/address hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
            r_d     <= '0;
            r_caddr <= '0;
            r_a     <= '0;
        end else if (w_wr_acc) begin
            r_cen   <= 1'b0;
            r_wen   <= 1'b0;
            r_caddr <= r_wcnt;
            r_d     <= wr_data;
        end else if (w_rd_acc) begin
            r_cen   <= 1'b0;
            r_wen   <= 1'b1;
            r_a     <= rd_addr;
        end else begin
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
        end
    end

    // Read return pipeline: track each accepted request until Q is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_p1    <= 1'b0;
            r_rd_p2    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_p1    <= w_rd_acc;
            r_rd_p2    <= r_rd_p1;
            r_rd_valid <= r_rd_p2;
            if (r_rd_p2) begin
                r_rd_data <= Q;
            end
        end
    end

    assign wr_ready  = r_wr_ready;
    assign rd_ready  = r_rd_ready;
    assign load_done = r_load_done;
    assign loaded    = r_loaded;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign CEN       = r_cen;
    assign WEN       = r_wen;
    assign D         = r_d;
    assign CADDR     = r_caddr;
    assign A         = r_a;

endmodule
`default_nettype wire

// File: doc/sram_8blk_ctrl.md
Name: sram_8blk_ctrl

Overview:
RTL master for the 8-block coefficient SRAM (sram_8blk, 8 x 256 x 20-bit) used by the FIR datapath.
- Load phase: accepts a 2048-word coefficient stream on a valid/ready port and writes it serially through the SRAM's shared CADDR/D port.
- Run phase: issues 8 parallel block reads per request and returns the 8 words to the FIR datapath with fixed latency.

Parameters:
DW, 20, data word width
AW, 8, per-block address width (256 words per block)
NBLK, 8, number of SRAM blocks (fixed at 8; CADDR width = AW+3 = 11)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse; begins a full coefficient load
wr_valid  in  1  coefficient beat valid
wr_data  in  20  coefficient word
wr_ready  out  1  controller accepts a beat this cycle
load_done  out  1  one-cycle pulse after the final beat is written
loaded  out  1  SRAM contents valid; cleared by load_start and by reset
rd_req  in  1  parallel read request
rd_addr  in  64  packed addresses; [8k+7:8k] is the address for block k
rd_ready  out  1  read request accepted when rd_req & rd_ready
rd_valid  out  1  rd_data valid
rd_data  out  160  packed read data; [20k+19:20k] is Qk
CEN  out  1  SRAM chip enable, active low
WEN  out  1  SRAM write enable, active low
D  out  20  SRAM write data
CADDR  out  11  SRAM write address; [10:8] selects block, [7:0] selects word
A  out  64  packed SRAM read addresses; A[8k+7:8k] drives Ak
Q  in  160  packed SRAM read data; Q[20k+19:20k] comes from Qk

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - Outputs: CEN=1, WEN=1, D=0, CADDR=0, A=0, wr_ready=0, load_done=0, loaded=0, rd_ready=0, rd_valid=0, rd_data=0.
  - Internal: FSM=IDLE, write counter wcnt=0, read pipeline empty.
- All SRAM-side outputs are registered. The SRAM samples them on the edge after they are driven and presents Q after that same edge.
- FSM states are IDLE, LOAD and DONE.
  - IDLE:
    - wr_ready=0; rd_ready=loaded.
    - load_start moves to LOAD, clears loaded and wcnt.
  - LOAD:
    - wr_ready=1; rd_ready=0.
    - Each accepted beat (wr_valid & wr_ready) registers CEN=0, WEN=0, CADDR=wcnt, D=wr_data, then wcnt++.
    - A cycle with no beat registers CEN=1, WEN=1.
    - The beat with wcnt==2047 moves to DONE.
    - load_start while in LOAD is ignored.
  - DONE: lasts one cycle. CEN=1, WEN=1, load_done=1, loaded set to 1, next state IDLE.
- Write ordering: beat n goes to block n[10:8], word n[7:0]. wcnt is 11 bits and never wraps within a load.
- Read pipeline:
  - Fully pipelined; one request per cycle; fixed latency of 2 cycles.
  - Cycle t, rd_req & rd_ready: register A=rd_addr, CEN=0, WEN=1.
  - Edge t+1: the SRAM captures the addresses; Q becomes valid.
  - Edge t+2: rd_data is captured from Q and rd_valid=1 for one cycle.
  - With back-to-back requests, rd_valid stays high continuously.
- Idle SRAM drive (no write beat and no read accepted): CEN=1, WEN=1. A and D hold their last value; CADDR holds its last value.
- rd_req while rd_ready=0 is dropped, not queued. rd_valid never asserts for a dropped request.
- Simultaneous load_start and rd_req in IDLE with loaded=1:
  - The read is accepted because rd_ready is computed from the current state.
  - LOAD begins the next cycle.
  - The in-flight read drains: rd_valid asserts 2 cycles later with the old contents.
- Reset during LOAD:
  - All state clears; loaded=0; the partial contents are treated as invalid.
  - A new load_start is required before rd_ready rises.
- Reset while reads are in flight: the reads are discarded and rd_valid stays 0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> CEN, WEN, wr_ready, rd_ready, rd_valid, loaded all take their reset values at once, without waiting for a clock edge.
- Full load, streamed: load_start, then 2048 beats with wr_data=(3n)%2^20 and wr_valid held high -> CADDR=n and D=3n on consecutive cycles with CEN=WEN=0; load_done pulses once, 1 cycle after beat 2047; loaded=1 afterwards.
- Backpressure gaps: wr_valid low every 3rd cycle during load -> CEN=WEN=1 on the gap cycles; wcnt and CADDR do not advance; the SRAM model contents still equal 3n.
- Parallel reads: after load, 4 back-to-back requests with block k address = (16r+k)%256 -> rd_valid high on 4 consecutive cycles starting 2 cycles after the first request; word k of each result = 3*(256k+addr_k)%2^20.
- Read gating: rd_req before any load, and rd_req during LOAD -> rd_ready=0; no CEN=0/WEN=1 cycle is issued; rd_valid stays 0.
- Abort: rst_n pulsed low at beat 100 of a load -> loaded=0 and rd_ready=0; a fresh load_start plus 2048 beats is required before any read is accepted.
